// File: rtl/enigma_ctrl.sv
// Rotor positioning and keystroke sequencer for rero; result latency SETTLE_CYCLES+3, held until out_ready.
// Optional ENIGMA_CTRL_SELFCHECK_EN flags (as index 31) a result equal to its own input letter.
module enigma_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_STEPS     = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_start,
    input  logic [4:0]  cfg_pos1,
    input  logic [4:0]  cfg_pos2,
    input  logic [4:0]  cfg_pos3,
    input  logic        key_valid,
    input  logic [4:0]  key_idx,
    output logic        key_ready,
    output logic        out_valid,
    output logic [4:0]  out_idx,
    input  logic        out_ready,
    output logic        busy,
    output logic        cfg_err,
    output logic [15:0] key_count,
    output logic [25:0] rero_in,
    input  logic [25:0] rero_out,
    output logic        rotate1,
    output logic        rotate2,
    output logic        rotate3,
    input  logic [4:0]  state1,
    input  logic [4:0]  state2,
`ifdef ENIGMA_CTRL_SELFCHECK_EN
    input  logic [4:0]  state3,
    output logic        selfcheck_err
`else
    input  logic [4:0]  state3
`endif
);
    localparam int SW = $clog2(MAX_STEPS + 1);

    typedef enum logic [2:0] {
        IDLE, CFG_CMP, CFG_PULSE, CFG_GAP, KEY_DRIVE, KEY_SAMPLE, KEY_GAP, OUT_HOLD
    } state_t;

    state_t        state, state_nxt;
    logic [4:0]    tgt1, tgt2, tgt3;
    logic [1:0]    rsel;
    logic [SW-1:0] steps;
    logic [3:0]    settle;
    logic [4:0]    key_lat;
    logic [4:0]    cur_pos, cur_tgt;
    logic          match, steps_max, settle_done, accept;
    logic          onehot;
    logic [4:0]    dec_idx;
    logic [4:0]    result;

    always_comb begin
        cur_pos = state3;
        cur_tgt = tgt3;
        case (rsel)
            2'd1: begin cur_pos = state1; cur_tgt = tgt1; end
            2'd2: begin cur_pos = state2; cur_tgt = tgt2; end
            default: ;
        endcase
    end

    assign match       = (cur_pos == cur_tgt);
    assign steps_max   = (steps == SW'(MAX_STEPS));
    assign settle_done = (settle == 4'(SETTLE_CYCLES - 1));
    assign accept      = key_valid && key_ready;

    always_comb begin
        dec_idx = 5'd0;
        for (int i = 0; i < 26; i++) begin
            if (rero_out[i]) dec_idx = 5'(i);
        end
        onehot = (rero_out != 26'd0) && ((rero_out & (rero_out - 26'd1)) == 26'd0);
    end

`ifdef ENIGMA_CTRL_SELFCHECK_EN
    assign result = (onehot && dec_idx != key_lat) ? dec_idx : 5'd31;
`else
    assign result = onehot ? dec_idx : 5'd31;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cfg_start)      state_nxt = CFG_CMP;
                else if (key_valid) state_nxt = (key_idx <= 5'd25) ? KEY_DRIVE : OUT_HOLD;
            end
            CFG_CMP: begin
                if (match)          state_nxt = (rsel == 2'd3) ? IDLE : CFG_CMP;
                else if (steps_max) state_nxt = IDLE;
                else                state_nxt = CFG_PULSE;
            end
            CFG_PULSE:  state_nxt = CFG_GAP;
            CFG_GAP:    state_nxt = CFG_CMP;
            KEY_DRIVE:  state_nxt = KEY_SAMPLE;
            KEY_SAMPLE: if (settle_done) state_nxt = KEY_GAP;
            KEY_GAP:    state_nxt = OUT_HOLD;
            OUT_HOLD:   if (out_ready) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tgt1      <= '0;
            tgt2      <= '0;
            tgt3      <= '0;
            rsel      <= 2'd1;
            steps     <= '0;
            settle    <= '0;
            key_lat   <= '0;
            out_idx   <= '0;
            cfg_err   <= 1'b0;
            key_count <= '0;
`ifdef ENIGMA_CTRL_SELFCHECK_EN
            selfcheck_err <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        tgt1    <= cfg_pos1;
                        tgt2    <= cfg_pos2;
                        tgt3    <= cfg_pos3;
                        cfg_err <= 1'b0;
                        rsel    <= 2'd1;
                        steps   <= '0;
                    end else if (accept) begin
                        key_lat <= key_idx;
                        if (key_idx > 5'd25) out_idx <= 5'd31;
                    end
                end
                CFG_CMP: begin
                    if (match) begin
                        rsel  <= rsel + 2'd1;
                        steps <= '0;
                    end else if (steps_max) begin
                        cfg_err <= 1'b1;
                    end
                end
                CFG_PULSE: steps  <= steps + 1'b1;
                KEY_DRIVE: settle <= '0;
                KEY_SAMPLE: begin
                    settle <= settle + 4'd1;
                    if (settle_done) begin
                        out_idx   <= result;
                        key_count <= key_count + 16'd1;
`ifdef ENIGMA_CTRL_SELFCHECK_EN
                        if (onehot && dec_idx == key_lat) selfcheck_err <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Collision rule: a pending cfg_start in IDLE blocks the keystroke handshake.
    assign key_ready = (state == IDLE) && !cfg_start && !reset;
    assign out_valid = (state == OUT_HOLD);
    assign busy      = (state != IDLE);
    assign rero_in   = (state == KEY_DRIVE || state == KEY_SAMPLE) ? (26'd1 << key_lat) : 26'd0;
    assign rotate1   = (state == CFG_PULSE) && (rsel == 2'd1);
    assign rotate2   = (state == CFG_PULSE) && (rsel == 2'd2);
    assign rotate3   = (state == CFG_PULSE) && (rsel == 2'd3);
endmodule

// File: tb/tb_enigma_ctrl.sv
// Directed bench for enigma_ctrl with a small behavioural rotor-position model.
module tb_enigma_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic [4:0]  cfg_pos1, cfg_pos2, cfg_pos3;
    logic        key_valid;
    logic [4:0]  key_idx;
    logic        key_ready;
    logic        out_valid;
    logic [4:0]  out_idx;
    logic        out_ready;
    logic        busy;
    logic        cfg_err;
    logic [15:0] key_count;
    logic [25:0] rero_in;
    logic [25:0] rero_out;
    logic        rotate1, rotate2, rotate3;
    logic [4:0]  pos1, pos2, pos3;
    logic [25:0] prev_in;
    logic [25:0] model_out;
`ifdef ENIGMA_CTRL_SELFCHECK_EN
    logic        selfcheck_err;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    enigma_ctrl dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start),
        .cfg_pos1(cfg_pos1), .cfg_pos2(cfg_pos2), .cfg_pos3(cfg_pos3),
        .key_valid(key_valid), .key_idx(key_idx), .key_ready(key_ready),
        .out_valid(out_valid), .out_idx(out_idx), .out_ready(out_ready),
        .busy(busy), .cfg_err(cfg_err), .key_count(key_count),
        .rero_in(rero_in), .rero_out(rero_out),
        .rotate1(rotate1), .rotate2(rotate2), .rotate3(rotate3),
        .state1(pos1), .state2(pos2),
`ifdef ENIGMA_CTRL_SELFCHECK_EN
        .state3(pos3), .selfcheck_err(selfcheck_err)
`else
        .state3(pos3)
`endif
    );

    // Rotor model: strobes step their rotor; a new non-zero key input steps rotor 1.
    assign rero_out = model_out;
    always @(posedge clk) begin
        if (reset) begin
            pos1 <= 5'd0; pos2 <= 5'd0; pos3 <= 5'd0; prev_in <= 26'd0;
        end else begin
            prev_in <= rero_in;
            if (rotate1 || (rero_in != 26'd0 && prev_in == 26'd0))
                pos1 <= (pos1 == 5'd25) ? 5'd0 : pos1 + 5'd1;
            if (rotate2) pos2 <= (pos2 == 5'd25) ? 5'd0 : pos2 + 5'd1;
            if (rotate3) pos3 <= (pos3 == 5'd25) ? 5'd0 : pos3 + 5'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_config(output int n1, output int n2, output int n3,
                              output int viol, output int cyc);
        logic prev;
        prev = 1'b0; n1 = 0; n2 = 0; n3 = 0; viol = 0; cyc = 0;
        while (busy === 1'b1 && cyc < 500) begin
            if (rotate1 + rotate2 + rotate3 > 1) viol++;
            if ((rotate1 || rotate2 || rotate3) && prev) viol++;
            if (rotate2 && n1 < int'(cfg_pos1) && cfg_pos1 < 5'd26) viol++;
            if (rotate3 && (n2 < int'(cfg_pos2) || n1 < int'(cfg_pos1))) viol++;
            n1 += int'(rotate1); n2 += int'(rotate2); n3 += int'(rotate3);
            prev = rotate1 || rotate2 || rotate3;
            tick();
            cyc++;
        end
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_start = 1'b0; key_valid = 1'b0; key_idx = 5'd0;
        cfg_pos1 = 5'd0; cfg_pos2 = 5'd0; cfg_pos3 = 5'd0;
        out_ready = 1'b1; model_out = 26'd0;
        repeat (3) tick();
        checks++; if (rero_in !== 26'd0) $display("FAIL reset_rero_in got %h want 0", rero_in); else passed++;
        checks++; if ({rotate1, rotate2, rotate3} !== 3'b000) $display("FAIL reset_rotates got %b want 000", {rotate1, rotate2, rotate3}); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (key_count !== 16'd0) $display("FAIL reset_key_count got %0d want 0", key_count); else passed++;
        checks++; if (key_ready !== 1'b0 || busy !== 1'b0) $display("FAIL reset_ready_busy got %b%b want 00", key_ready, busy); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (key_ready !== 1'b1) $display("FAIL release_key_ready got %b want 1", key_ready); else passed++;
        tick();
    endtask

    task automatic test_config();
        int n1, n2, n3, viol, cyc;
        cfg_pos1 = 5'd3; cfg_pos2 = 5'd5; cfg_pos3 = 5'd7;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        run_config(n1, n2, n3, viol, cyc);
        checks++; if (cyc >= 500) $display("FAIL cfg_timeout busy still %b after %0d cycles", busy, cyc); else passed++;
        checks++; if (n1 != 3 || n2 != 5 || n3 != 7) $display("FAIL cfg_pulses got %0d/%0d/%0d want 3/5/7", n1, n2, n3); else passed++;
        checks++; if (viol != 0) $display("FAIL cfg_pulse_shape got %0d violations want 0", viol); else passed++;
        checks++; if (cfg_err !== 1'b0) $display("FAIL cfg_err_clean got %b want 0", cfg_err); else passed++;
        checks++; if ({pos1, pos2, pos3} !== {5'd3, 5'd5, 5'd7}) $display("FAIL cfg_positions got %0d/%0d/%0d want 3/5/7", pos1, pos2, pos3); else passed++;
    endtask

    task automatic test_cfg_err();
        int n1, n2, n3, viol, cyc;
        cfg_pos1 = 5'd30; cfg_pos2 = 5'd9; cfg_pos3 = 5'd9;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        run_config(n1, n2, n3, viol, cyc);
        checks++; if (cyc >= 500) $display("FAIL cfgerr_timeout busy still %b", busy); else passed++;
        checks++; if (n1 != 26 || n2 != 0 || n3 != 0) $display("FAIL cfgerr_pulses got %0d/%0d/%0d want 26/0/0", n1, n2, n3); else passed++;
        checks++; if (cfg_err !== 1'b1 || key_ready !== 1'b1) $display("FAIL cfgerr_flag got err=%b ready=%b want 1 1", cfg_err, key_ready); else passed++;
    endtask

    task automatic test_keystroke();
        logic [4:0] p1_before;
        logic       in_ok, ov_early;
        p1_before = pos1;
        model_out = 26'd1 << 7; out_ready = 1'b1;
        key_idx = 5'd0; key_valid = 1'b1;
        #1;
        checks++; if (key_ready !== 1'b1) $display("FAIL key_ready_idle got %b want 1", key_ready); else passed++;
        tick();
        key_valid = 1'b0;
        in_ok = 1'b1; ov_early = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (rero_in !== 26'h1) in_ok = 1'b0;
            if (out_valid !== 1'b0) ov_early = 1'b1;
            tick();
        end
        checks++; if (!in_ok) $display("FAIL key_drive rero_in not 26'h1 for 3 cycles (last %h)", rero_in); else passed++;
        checks++; if (rero_in !== 26'd0 || out_valid !== 1'b0) $display("FAIL key_gap got in=%h valid=%b want 0 0", rero_in, out_valid); else passed++;
        tick();
        checks++; if (ov_early || out_valid !== 1'b1) $display("FAIL key_latency valid=%b early=%b want valid on 5th edge", out_valid, ov_early); else passed++;
        checks++; if (out_idx !== 5'd7) $display("FAIL key_out_idx got %0d want 7", out_idx); else passed++;
        checks++; if (key_count !== 16'd1) $display("FAIL key_count1 got %0d want 1", key_count); else passed++;
        checks++; if (pos1 !== p1_before + 5'd1) $display("FAIL key_rotor_step got %0d want %0d", pos1, p1_before + 5'd1); else passed++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL key_release got valid=%b want 0", out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        int cyc, bad_hold, bad_ready;
        logic [4:0] p1_before;
        model_out = 26'd1 << 12; out_ready = 1'b0;
        key_idx = 5'd3; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        wait_out(cyc);
        checks++; if (cyc >= 20) $display("FAIL bp_timeout no out_valid after %0d cycles", cyc); else passed++;
        bad_hold = 0; bad_ready = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid !== 1'b1 || out_idx !== 5'd12) bad_hold++;
            if (key_ready !== 1'b0) bad_ready++;
            tick();
        end
        checks++; if (bad_hold != 0) $display("FAIL bp_hold got %0d unstable cycles want 0", bad_hold); else passed++;
        checks++; if (bad_ready != 0) $display("FAIL bp_key_ready got %0d ready cycles want 0", bad_ready); else passed++;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || key_count !== 16'd2) $display("FAIL bp_release valid=%b count=%0d want 0 2", out_valid, key_count); else passed++;

        model_out = 26'h3; key_idx = 5'd4; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        wait_out(cyc);
        checks++; if (out_idx !== 5'd31 || key_count !== 16'd3) $display("FAIL multi_hot got idx=%0d count=%0d want 31 3", out_idx, key_count); else passed++;
        tick();

        p1_before = pos1;
        key_idx = 5'd27; key_valid = 1'b1;
        #1;
        checks++; if (rero_in !== 26'd0) $display("FAIL bad_key_accept_cycle rero_in=%h want 0", rero_in); else passed++;
        tick();
        key_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_idx !== 5'd31) $display("FAIL bad_key_out valid=%b idx=%0d want 1 31", out_valid, out_idx); else passed++;
        checks++; if (rero_in !== 26'd0 || key_count !== 16'd3 || pos1 !== p1_before) $display("FAIL bad_key_side in=%h count=%0d pos1=%0d want 0 3 %0d", rero_in, key_count, pos1, p1_before); else passed++;
        tick();
    endtask

    task automatic test_collision();
        int n1, n2, n3, viol, cyc;
        cfg_pos1 = (pos1 >= 5'd24) ? pos1 - 5'd24 : pos1 + 5'd2;
        cfg_pos2 = pos2; cfg_pos3 = pos3;
        cfg_start = 1'b1; key_valid = 1'b1; key_idx = 5'd5;
        #1;
        checks++; if (key_ready !== 1'b0) $display("FAIL collide_key_ready got %b want 0", key_ready); else passed++;
        tick();
        cfg_start = 1'b0; key_valid = 1'b0;
        run_config(n1, n2, n3, viol, cyc);
        checks++; if (n1 != 2 || n2 != 0 || n3 != 0 || viol != 0) $display("FAIL collide_cfg got %0d/%0d/%0d viol=%0d want 2/0/0 0", n1, n2, n3, viol); else passed++;
        checks++; if (cfg_err !== 1'b0 || key_count !== 16'd3) $display("FAIL collide_state err=%b count=%0d want 0 3", cfg_err, key_count); else passed++;
        model_out = 26'd1 << 9; key_valid = 1'b1;
        #1;
        checks++; if (key_ready !== 1'b1) $display("FAIL collide_after_ready got %b want 1", key_ready); else passed++;
        tick();
        key_valid = 1'b0;
        wait_out(cyc);
        checks++; if (out_idx !== 5'd9 || key_count !== 16'd4) $display("FAIL collide_key got idx=%0d count=%0d want 9 4", out_idx, key_count); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        cfg_pos1 = (pos1 >= 5'd21) ? pos1 - 5'd21 : pos1 + 5'd5;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cyc = 0;
        while (rotate1 !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++; if (cyc >= 20) $display("FAIL mid_no_pulse rotate1=%b after %0d cycles", rotate1, cyc); else passed++;
        reset = 1'b1;
        tick();
        checks++; if ({rotate1, rotate2, rotate3} !== 3'b000 || busy !== 1'b0) $display("FAIL mid_reset rot=%b busy=%b want 000 0", {rotate1, rotate2, rotate3}, busy); else passed++;
        checks++; if (key_count !== 16'd0 || out_valid !== 1'b0 || cfg_err !== 1'b0) $display("FAIL mid_reset_clear count=%0d valid=%b err=%b want 0 0 0", key_count, out_valid, cfg_err); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (key_ready !== 1'b1) $display("FAIL mid_release_ready got %b want 1", key_ready); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_config();
        test_cfg_err();
        test_keystroke();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/enigma_ctrl.md
Name: enigma_ctrl

Overview:
Sequencing controller for the rotor/reflector stack (rero). It runs two operations:
- Set the three rotors to target start positions by pulsing the per-rotor rotate strobes.
- Run encipher keystrokes: one letter index in, one letter index out, each with a valid/ready handshake.

It sits between the keyboard/host logic and rero, converting 5-bit indices to and from the 26-bit one-hot buses.

Parameters:
- SETTLE_CYCLES, 2: cycles the one-hot input is held on rero_in before rero_out is sampled (range 1..15).
- MAX_STEPS, 26: per-rotor step limit during configuration before a config error is declared.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- cfg_start  input  1  one-cycle request to set rotor positions
- cfg_pos1, cfg_pos2, cfg_pos3  input  5 each  target positions 0..25 for rotors 1/2/3
- key_valid  input  1  keystroke request
- key_idx  input  5  letter index 0..25
- key_ready  output  1  controller can accept a keystroke
- out_valid  output  1  result available
- out_idx  output  5  enciphered letter index; 31 means error
- out_ready  input  1  consumer accepts the result
- busy  output  1  high in any state other than IDLE
- cfg_err  output  1  sticky; set when a rotor fails to reach its target; cleared by reset or the next cfg_start
- key_count  output  16  number of accepted, valid keystrokes; wraps at 65535 -> 0
- rero_in  output  26  one-hot drive to rero.in
- rero_out  input  26  rero.out
- rotate1, rotate2, rotate3  output  1 each  step strobes to rero
- state1, state2, state3  input  5 each  current rotor positions from rero

Behaviour:
- Reset (synchronous): all outputs 0, key_ready 0, FSM enters IDLE; key_ready goes 1 on the first cycle after reset is released.
- Reset mid-operation: immediate return to IDLE. rero_in and rotates are 0 on the next edge. Any pending out_valid is dropped and counters cleared.
- FSM states: IDLE, CFG_CMP, CFG_PULSE, CFG_GAP, KEY_DRIVE, KEY_SAMPLE, KEY_GAP, OUT_HOLD.
- IDLE: key_ready = 1.
  - cfg_start has priority: if cfg_start=1 and key_valid=1 in the same cycle, the key is not accepted (key_ready forced 0 that cycle).
  - On cfg_start: latch cfg_pos1..3, clear cfg_err, set rotor select r=1, step count=0, go to CFG_CMP.
  - On key_valid (accept = valid & ready): latch key_idx. If key_idx <= 25, go to KEY_DRIVE. If key_idx >= 26, go straight to OUT_HOLD with out_idx=31; key_count is not incremented and rero is not driven.
- CFG_CMP:
  - If state_r == latched target_r: advance r (order 1, 2, 3 is mandatory, because rotor 1 may carry into 2 and rotor 2 into 3), reset step count, stay in CFG_CMP; after r=3, go to IDLE.
  - Else, if step count == MAX_STEPS: set cfg_err, go to IDLE.
  - Else go to CFG_PULSE.
  - A target >= 26 never matches and ends in cfg_err.
- CFG_PULSE: rotate_r = 1 for exactly one cycle, increment step count, go to CFG_GAP.
- CFG_GAP: all rotates 0 for one cycle, then go to CFG_CMP.
- KEY_DRIVE: rero_in = 1 << key_idx. This non-zero input steps rotor 1 inside rero. rotate1..3 stay 0. Go to KEY_SAMPLE.
- KEY_SAMPLE:
  - Keep driving rero_in for SETTLE_CYCLES cycles, then register rero_out.
  - If exactly one bit is set, out_idx = its index; otherwise out_idx = 31.
  - key_count += 1. Go to KEY_GAP.
- KEY_GAP: rero_in = 0 for one cycle (releases the key), then go to OUT_HOLD.
- OUT_HOLD:
  - out_valid = 1; out_idx is held stable until out_valid & out_ready.
  - On the handshake, the next state is IDLE and out_valid drops on the next edge.
  - out_ready high before out_valid has no effect.
- Latency, valid key with out_ready tied high: accept edge to out_valid = SETTLE_CYCLES + 3 cycles (5 at default).
- busy = 1 in every state except IDLE. cfg_start while busy is ignored (not queued).

Optional Feature:
- Macro: ENIGMA_CTRL_SELFCHECK_EN.
- Defined: in KEY_SAMPLE, a one-hot output equal to the input letter (impossible with a valid reflector) also produces out_idx = 31 and sets a sticky internal flag, exported as extra output selfcheck_err (1 bit, cleared by reset).
- Undefined: no check, no selfcheck_err port; only the non-one-hot rule produces 31.

Test Plan:
- Reset then idle: hold reset 3 cycles -> rero_in=0, rotates=0, out_valid=0, key_count=0; key_ready=1 on the first cycle after release.
- Config from all-zero rotor model, cfg_pos=3/5/7: exactly 3 rotate1 pulses, then 5 rotate2, then 7 rotate3, each pulse 1 cycle wide with ≥1 low cycle between; cfg_err=0; busy falls after the final compare.
- Config target cfg_pos1=30 -> 26 rotate1 pulses, then cfg_err=1, FSM back in IDLE, no rotate2/rotate3 pulses.
- Keystroke key_idx=0 with a model returning rero_out=1<<7:
  - rero_in=26'h1 for 3 cycles, then 0;
  - out_valid after 5 cycles with out_idx=7;
  - key_count=1; state1 advances by 1.
- Backpressure and invalid key:
  - out_ready=0 for 10 cycles -> out_valid and out_idx stable, key_ready=0 throughout.
  - key_idx=27 -> no rero_in activity; out_idx=31; key_count unchanged.
- Collision and reset:
  - cfg_start and key_valid in the same cycle -> key_ready=0, config runs, key accepted afterwards.
  - reset asserted during CFG_PULSE -> rotates 0 on the next edge, IDLE.
